dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus LED/switch I/O registers behind a
// req/ready handshake with a configurable number of wait states.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] IO_BASE     = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [7:0]  sw,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [7:0]  led
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] RAM_LIMIT = 32'(4 * DEPTH);
  localparam logic [31:0] SW_ADDR   = IO_BASE + 32'd4;
  localparam logic [3:0]  LAST_CNT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              enter_resp;
  logic              we_q;
  logic [31:0]       addr_q, wdata_q;
  logic [7:0]        sw_s1, sw_s2;
  logic              t_we;
  logic [31:0]       t_addr, t_wdata;
  logic              hit_ram, hit_led, hit_sw, fault;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       load_val;

  logic [31:0] RAM [DEPTH];

  // Transaction view: live inputs on the acceptance edge, captured copy afterwards
  always_comb begin
    t_we    = we_q;
    t_addr  = addr_q;
    t_wdata = wdata_q;
    if (state == IDLE) begin
      t_we    = we;
      t_addr  = addr;
      t_wdata = wdata;
    end
  end

  // Next-state logic; enter_resp marks the edge that commits stores and loads data
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_nx = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_nx   = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
          cnt_nx     = 4'd0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address decode and fault classification for the current transaction
  always_comb begin
    hit_ram  = (t_addr < RAM_LIMIT);
    hit_led  = (t_addr == IO_BASE);
    hit_sw   = (t_addr == SW_ADDR);
    fault    = (t_addr[1:0] != 2'b00) || !(hit_ram || hit_led || hit_sw) || (hit_sw && t_we);
    idx      = t_addr[IDX_W+1:2];
    load_val = {24'd0, sw_s2};
    if (hit_ram) begin
      load_val = RAM[idx];
    end else if (hit_led) begin
      load_val = {24'd0, led};
    end
  end

  // State and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the request on acceptance so later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Two-flop synchronizer for the switch inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1 <= 8'd0;
      sw_s2 <= 8'd0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // Response outputs and LED register; response fields are zero outside the pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= 32'd0;
      err   <= 1'b0;
      led   <= 8'd0;
    end else begin
      ready <= enter_resp;
      rdata <= 32'd0;
      err   <= 1'b0;
      if (enter_resp) begin
        err   <= fault;
        rdata <= (fault || t_we) ? 32'd0 : load_val;
        if (t_we && hit_led && !fault) begin
          led <= t_wdata[7:0];
        end
      end
    end
  end

  // RAM store port; not reset so contents survive reset
  always_ff @(posedge clk) begin
    if (rst && enter_resp && t_we && hit_ram && !fault) begin
      RAM[idx] <= t_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (1, 3 and 0 wait states)
// checked against a behavioural memory/I/O model.
module tb_dmem_responder;

  localparam logic [31:0] IO_BASE = 32'h0000_0400;
  localparam int          DEPTH   = 64;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        ferr;
    int          acc;
  } exp_t;

  logic        clk;
  logic [2:0]  rst, req, we, ready, err;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [7:0]  sw [3];
  logic [7:0]  led [3];

  exp_t        sb[$];
  exp_t        me;
  int          rcyc2[$];
  logic [31:0] mref [3][DEPTH];
  logic [7:0]  lref [3];
  logic [7:0]  swref [3];
  logic [2:0]  prev_rdy;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1), .IO_BASE(IO_BASE)) u0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .sw(sw[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .led(led[0]));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .IO_BASE(IO_BASE)) u1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .sw(sw[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .led(led[1]));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .IO_BASE(IO_BASE)) u2 (
    .clk(clk), .rst(rst[2]), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
    .sw(sw[2]), .ready(ready[2]), .rdata(rdata[2]), .err(err[2]), .led(led[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  // Reference model: memory map rules applied directly to the address
  function automatic void predict(input int i, input logic w, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] ed, output logic ee);
    ed = 32'd0;
    ee = 1'b0;
    if (a % 4 != 0) ee = 1'b1;
    else if (a < 4 * DEPTH) begin
      if (w) mref[i][a / 4] = d;
      else   ed = mref[i][a / 4];
    end else if (a == IO_BASE) begin
      if (w) lref[i] = d[7:0];
      else   ed = {24'd0, lref[i]};
    end else if (a == IO_BASE + 32'd4) begin
      if (w) ee = 1'b1;
      else   ed = {24'd0, swref[i]};
    end else ee = 1'b1;
  endfunction

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    logic [31:0] ed;
    logic        ee;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    predict(i, w, a, d, ed, ee);
    e.inst = i; e.data = ed; e.ferr = ee; e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d responses still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Drop req and scramble the request inputs while the access is in flight
  task automatic finish_txn(input int i);
    @(negedge clk);
    req[i] = 1'b0; we[i] = 1'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
    wait_empty();
  endtask

  task automatic check_ram0();
    int bad = 0;
    for (int j = 0; j < DEPTH; j++) if (u0.RAM[j] !== mref[0][j]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_contents: %0d words differ, required 0", bad);
    end
  endtask

  // Monitor: pop and compare on every ready pulse, check quiet outputs otherwise
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev_rdy[i] === 1'b1) begin
        checks++;
        if (ready[i]) begin
          errors++;
          $display("FAIL ready_width inst %0d: ready high for 2+ cycles, required 1", i);
        end
      end
      if (ready[i]) begin
        if (i == 2) rcyc2.push_back(cyc);
        if (sb.size() == 0 || sb[0].inst != i) begin
          checks++; errors++;
          $display("FAIL unexpected_ready inst %0d: ready=1, required 0", i);
        end else begin
          me = sb.pop_front();
          checks += 3;
          if (rdata[i] !== me.data) begin
            errors++;
            $display("FAIL rdata inst %0d: got %h, required %h", i, rdata[i], me.data);
          end
          if (err[i] !== me.ferr) begin
            errors++;
            $display("FAIL err inst %0d: got %b, required %b", i, err[i], me.ferr);
          end
          if (cyc + 1 - me.acc != wc(i) + 1) begin
            errors++;
            $display("FAIL latency inst %0d: got %0d edges, required %0d", i, cyc + 1 - me.acc, wc(i) + 1);
          end
        end
      end else begin
        checks++;
        if (rdata[i] !== 32'd0 || err[i] !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs inst %0d: rdata=%h err=%b, required 0/0", i, rdata[i], err[i]);
        end
      end
      prev_rdy[i] = ready[i];
    end
  end

  initial begin
    logic [31:0] a, v;
    int          k;
    rst = 3'b111; req = 3'b000; we = 3'b000; prev_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 32'd0; wdata[i] = 32'd0; sw[i] = 8'd0; lref[i] = 8'd0; swref[i] = 8'd0;
    end
    for (int j = 0; j < DEPTH; j++) begin
      v = $urandom; u0.RAM[j] = v; mref[0][j] = v;
      v = $urandom; u1.RAM[j] = v; mref[1][j] = v;
      v = $urandom; u2.RAM[j] = v; mref[2][j] = v;
    end
    u0.RAM[0] = 32'd10; mref[0][0] = 32'd10;
    u0.RAM[1] = 32'd20; mref[0][1] = 32'd20;
    #1 rst = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready[i] !== 1'b0 || rdata[i] !== 32'd0 || err[i] !== 1'b0 || led[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_state inst %0d: ready=%b rdata=%h err=%b led=%h, required all 0",
                 i, ready[i], rdata[i], err[i], led[i]);
      end
    end
    @(negedge clk) rst = 3'b111;

    // Preloaded loads
    issue(0, 1'b0, 32'd0, 32'd0); finish_txn(0);
    issue(0, 1'b0, 32'd4, 32'd0); finish_txn(0);

    // Store then load back
    issue(0, 1'b1, 32'd8, 32'd80); finish_txn(0);
    checks++;
    if (u0.RAM[2] !== 32'd80) begin
      errors++;
      $display("FAIL ram2_store: got %0d, required 80", u0.RAM[2]);
    end
    issue(0, 1'b0, 32'd8, 32'd0); finish_txn(0);

    // LED store, switch read through synchronizer
    issue(0, 1'b1, IO_BASE, 32'h1A5); finish_txn(0);
    checks++;
    if (led[0] !== 8'hA5) begin
      errors++;
      $display("FAIL led_store: got %h, required a5", led[0]);
    end
    sw[0] = 8'h3C;
    repeat (3) @(negedge clk);
    swref[0] = 8'h3C;
    issue(0, 1'b0, IO_BASE + 32'd4, 32'd0); finish_txn(0);

    // Faulting accesses
    issue(0, 1'b0, 32'd2, 32'd0); finish_txn(0);
    issue(0, 1'b0, 32'h300, 32'd0); finish_txn(0);
    issue(0, 1'b1, IO_BASE + 32'd4, 32'h55); finish_txn(0);
    checks++;
    if (led[0] !== lref[0]) begin
      errors++;
      $display("FAIL led_after_faults: got %h, required %h", led[0], lref[0]);
    end
    check_ram0();

    // Reset during wait states aborts the store
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'd12; wdata[1] = ~mref[1][3];
    @(negedge clk) req[1] = 1'b0;
    @(negedge clk) rst[1] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (u1.RAM[3] !== mref[1][3]) begin
      errors++;
      $display("FAIL abort_ram3: got %h, required %h", u1.RAM[3], mref[1][3]);
    end
    if (led[1] !== 8'd0) begin
      errors++;
      $display("FAIL abort_led: got %h, required 00", led[1]);
    end
    @(negedge clk) rst[1] = 1'b1;
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 32'd12, 32'd0); finish_txn(1);

    // Back-to-back loads with no wait states, addr changed after each acceptance
    issue(2, 1'b0, 32'd20, 32'd0);
    for (int n = 1; n < 3; n++) begin
      @(negedge clk);
      addr[2] = 32'(4 * (n * 7));
      predict(2, 1'b0, addr[2], 32'd0, me.data, me.ferr);
      sb.push_back('{inst: 2, data: me.data, ferr: me.ferr, acc: cyc + 2});
      @(negedge clk);
    end
    @(negedge clk) req[2] = 1'b0;
    wait_empty();
    checks++;
    if (rcyc2.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, required 3", rcyc2.size());
    end else begin
      for (int n = 1; n < 3; n++) begin
        checks++;
        if (rcyc2[n] - rcyc2[n-1] != 2) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles, required 2", rcyc2[n] - rcyc2[n-1]);
        end
      end
    end

    // Randomised traffic on the one-wait-state instance
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      a = 32'(4 * $urandom_range(0, DEPTH - 1));
      else if (k == 6) a = IO_BASE;
      else if (k == 7) a = IO_BASE + 32'd4;
      else if (k == 8) a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else             a = 32'(32'h100 + 4 * $urandom_range(0, 63));
      issue(0, 1'($urandom_range(0, 1)), a, $urandom);
      finish_txn(0);
    end
    check_ram0();
    checks++;
    if (led[0] !== lref[0]) begin
      errors++;
      $display("FAIL led_final: got %h, required %h", led[0], lref[0]);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
